// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal register (hold / shift right / shift left / load)
// with a shift counter and an end-of-word pulse for framing serial words.
//
// Parameters:
//   WIDTH      register width in bits, >= 2
//   RESET_VAL  value of dout while reset is low
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   en         operation enable, 0 holds everything
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   din        parallel load data
//   sin_r      serial in at the MSB on a right shift
//   sin_l      serial in at the LSB on a left shift
//   dout       register contents
//   sout_r     dout[0]
//   sout_l     dout[WIDTH-1]
//   bit_cnt    shifts since the last load or wrap
//   word_done  one-cycle pulse after the WIDTH-th shift of a word
//
// Build option: define UNIV_SR_ROTATE_EN to make the shift modes rotate;
// sin_r and sin_l are then ignored.

module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         din,
  input  logic                     sin_r,
  input  logic                     sin_l,
  output logic [WIDTH-1:0]         dout,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     word_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             bit_r;
  logic             bit_l;
  logic             shift;
  logic             wrap;

`ifdef UNIV_SR_ROTATE_EN
  logic unused_sin;
  assign unused_sin = sin_r ^ sin_l;
  assign bit_r = dout_q[0];
  assign bit_l = dout_q[WIDTH-1];
`else
  assign bit_r = sin_r;
  assign bit_l = sin_l;
`endif

  assign shift = en && (mode == 2'b01 || mode == 2'b10);
  assign wrap  = (cnt_q == LAST);

  always_comb begin
    dout_d = dout_q;
    if (en) begin
      case (mode)
        2'b01:   dout_d = {bit_r, dout_q[WIDTH-1:1]};
        2'b10:   dout_d = {dout_q[WIDTH-2:0], bit_l};
        2'b11:   dout_d = din;
        default: dout_d = dout_q;
      endcase
    end
  end

  // Direction changes share one count; a load restarts the word.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en && mode == 2'b11) begin
      cnt_d = '0;
    end else if (shift) begin
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      done_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign dout      = dout_q;
  assign sout_r    = dout_q[0];
  assign sout_l    = dout_q[WIDTH-1];
  assign bit_cnt   = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed scenarios plus random ops for univ_shift_reg,
// checked against an arithmetic reference model.

module tb_univ_shift_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] din;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] dout;
  logic         sout_r;
  logic         sout_l;
  logic [2:0]   bit_cnt;
  logic         word_done;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned  m_dout;
  int           m_shifts;
  bit           m_done;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .dout      (dout),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_dout   = RV;
    m_shifts = 0;
    m_done   = 0;
  endtask

  // Word framing: count shifts in the current word; the WIDTH-th one
  // completes the word.
  task automatic model_step();
    int unsigned in_r;
    int unsigned in_l;
    m_done = 0;
    if (!en || mode == 2'd0) return;
    if (mode == 2'd3) begin
      m_dout   = din;
      m_shifts = 0;
      return;
    end
`ifdef UNIV_SR_ROTATE_EN
    in_r = m_dout % 2;
    in_l = m_dout / 128;
`else
    in_r = sin_r;
    in_l = sin_l;
`endif
    if (mode == 2'd1) m_dout = m_dout / 2 + in_r * 128;
    else              m_dout = (m_dout * 2) % 256 + in_l;
    m_shifts = m_shifts + 1;
    if (m_shifts == W) begin
      m_done   = 1;
      m_shifts = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, 32'(dout), m_dout);
    check({tag, ".cnt"},  32'(bit_cnt), m_shifts);
    check({tag, ".done"}, 32'(word_done), 32'(m_done));
    check({tag, ".sr"},   32'(sout_r), m_dout % 2);
    check({tag, ".sl"},   32'(sout_l), m_dout / 128);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic [1:0] m,
                       input logic [W-1:0] d, input logic r,
                       input logic l);
    en    = e;
    mode  = m;
    din   = d;
    sin_r = r;
    sin_l = l;
  endtask

  // Called just after an edge: reset must act before the next edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".cnt0"}, 32'(bit_cnt), 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] sipo_bits;
    logic [7:0] piso_seq;
    reset = 1'b1;
    drive(0, 2'd0, '0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("por");
    check("por.a5", 32'(dout), 32'h A5);
    @(negedge clk);
    reset = 1'b1;

    // Parallel in, parallel out
    drive(1, 2'd3, 8'h3C, 0, 0);
    cycle("pipo.ld");
    drive(1, 2'd0, 8'h00, 1, 1);
    repeat (3) cycle("pipo.hold");
    check("pipo.3c", 32'(dout), 32'h3C);
    drive(0, 2'd3, 8'hFF, 0, 0);
    cycle("pipo.en0");
    check("pipo.keep", 32'(dout), 32'h3C);

`ifndef UNIV_SR_ROTATE_EN
    // Serial in, parallel out
    sipo_bits = 8'b0100_1101;
    for (int i = 0; i < W; i++) begin
      drive(1, 2'd1, '0, sipo_bits[i], 0);
      cycle("sipo");
    end
    check("sipo.4d", 32'(dout), 32'h4D);
    check("sipo.done", 32'(word_done), 1);
    check("sipo.cnt", 32'(bit_cnt), 0);
    drive(1, 2'd0, '0, 0, 0);
    cycle("sipo.after");
    check("sipo.pulse1", 32'(word_done), 0);

    // Parallel in, serial out
    drive(1, 2'd3, 8'h81, 0, 0);
    cycle("piso.ld");
    piso_seq = 8'b1000_0001;
    for (int i = 0; i < W; i++) begin
      check("piso.sout", 32'(sout_l), 32'(piso_seq[i]));
      drive(1, 2'd2, '0, 0, 0);
      cycle("piso");
    end
    check("piso.00", 32'(dout), 0);
    check("piso.done", 32'(word_done), 1);
`else
    // Rotate build: a full word of rotates restores the value
    drive(1, 2'd3, 8'h81, 1, 1);
    cycle("rot.ld");
    drive(1, 2'd1, '0, 1, 1);
    cycle("rot.r1");
    check("rot.c0", 32'(dout), 32'hC0);
    repeat (W - 1) cycle("rot.r");
    check("rot.81", 32'(dout), 32'h81);
    check("rot.done", 32'(word_done), 1);
`endif

    // Reset in the middle of a word
    drive(1, 2'd1, '0, 1, 0);
    repeat (5) cycle("mid.sh");
    pulse_reset("mid.rst");
    for (int i = 0; i < W; i++) begin
      drive(1, (i % 2) ? 2'd2 : 2'd1, '0, 1, 0);
      cycle("mid.re");
      check("mid.done", 32'(word_done), (i == W - 1) ? 1 : 0);
    end

    // Random operations, mostly enabled, with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0,
            2'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) != 0)
        mode = $urandom_range(1, 2);
      cycle("rnd");
      if ($urandom_range(0, 199) == 0)
        pulse_reset("rnd.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
